count_reach_monitor: RTL

Synthesizable run-time monitor that checks the consumer side of the bounded-counter interface. It watches a free-running count bus after reset release and reports whether the count reaches a target value within a bounded number of cycles. It also flags illegal count steps. It sits beside the bounded counter in the design and mirrors the bench-level reach assertion in hardware, so silicon and emulation can report the same failure.

---
 rtl/count_mon_pkg.sv | 22 ++
 rtl/count_step_checker.sv | 27 ++
 rtl/count_reach_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count reach monitor.
package count_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PASS,
        FAIL
    } mon_state_t;

    // A step is legal when the count holds or advances by one, wrapping at 2**width.
    function automatic logic step_legal(input logic [31:0] prev,
                                        input logic [31:0] cur,
                                        input int unsigned width);
        logic [31:0] mask;
        logic [31:0] next_val;
        mask     = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        next_val = (prev + 32'd1) & mask;
        return ((cur & mask) == (prev & mask)) || ((cur & mask) == next_val);
    endfunction

endpackage

// File: rtl/count_step_checker.sv
// Tracks the previous count and pulses step_bad for any step that is neither a hold nor +1.
module count_step_checker
    import count_mon_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] count,
    input  logic          load,
    input  logic          en,
    output logic          step_bad
);

    logic [CW-1:0] prev_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_count <= '0;
        end else if (load || en) begin
            prev_count <= count;
        end
    end

    assign step_bad = en && !step_legal(32'(prev_count), 32'(count), CW);

endmodule

// File: rtl/count_reach_monitor.sv
// Run-time monitor: the count must reach TARGET within MAX_CYCLES edges of arming.
//   state | meaning
//   IDLE  | reset held; leaves unconditionally on the first edge after release
//   WAIT  | window open, elapsed counts edges since arming
//   PASS  | TARGET seen inside the window; holds until start
//   FAIL  | window expired without TARGET; holds until start
module count_reach_monitor
    import count_mon_pkg::*;
#(
    parameter int            CW         = 4,
    parameter logic [CW-1:0] TARGET     = 4'hA,
    parameter int            MAX_CYCLES = 10,
    parameter int            EW         = $clog2(MAX_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] count,
    input  logic          start,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic          done,
    output logic [EW-1:0] hit_cycle,
    output logic          step_err
);

    localparam logic [EW-1:0] MAX_E = EW'(MAX_CYCLES);

    mon_state_t    state, state_nxt;
    logic [EW-1:0] elapsed, elapsed_nxt;
    logic [EW-1:0] hit_nxt;
    logic [EW-1:0] k;
    logic          pass_nxt, fail_nxt, step_err_nxt;
    logic          load;
    logic          step_bad;

    count_step_checker #(.CW(CW)) u_step (
        .clk      (clk),
        .reset_n  (reset_n),
        .count    (count),
        .load     (load),
        .en       (busy),
        .step_bad (step_bad)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            elapsed   <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            hit_cycle <= '0;
            step_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            elapsed   <= elapsed_nxt;
            pass      <= pass_nxt;
            fail      <= fail_nxt;
            hit_cycle <= hit_nxt;
            step_err  <= step_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        elapsed_nxt  = elapsed;
        pass_nxt     = pass;
        fail_nxt     = fail;
        hit_nxt      = hit_cycle;
        step_err_nxt = step_err;
        load         = 1'b0;
        k            = (elapsed == MAX_E) ? MAX_E : elapsed + 1'b1;

        case (state)
            IDLE: begin
                load        = 1'b1;
                state_nxt   = WAIT;
                elapsed_nxt = '0;
            end
            WAIT: begin
                elapsed_nxt = k;
                if (step_bad) begin
                    step_err_nxt = 1'b1;
                end
                // A match on the expiry edge still counts as a pass.
                if (count == TARGET) begin
                    state_nxt = PASS;
                    pass_nxt  = 1'b1;
                    hit_nxt   = k;
                end else if (k == MAX_E) begin
                    state_nxt = FAIL;
                    fail_nxt  = 1'b1;
                end
            end
            PASS, FAIL: begin
                if (start) begin
                    load         = 1'b1;
                    state_nxt    = WAIT;
                    elapsed_nxt  = '0;
                    pass_nxt     = 1'b0;
                    fail_nxt     = 1'b0;
                    hit_nxt      = '0;
                    step_err_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);
    assign done = pass | fail;

endmodule
